instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter IRQ_VECTOR, default 32'h0000_0500, meaning the interrupt handler entry address (word 320).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit: downstream cannot accept; hold PC and outputs.
REQ-006 The block SHALL have port redirect_valid, input, 1 bit: a branch or jump was taken downstream.
REQ-007 The block SHALL have port redirect_pc, input, 32 bits: target of the taken branch or jump.
REQ-008 The block SHALL have port irq, input, 1 bit: level-sensitive external interrupt request.
REQ-009 The block SHALL have port mret, input, 1 bit: mret was executed downstream.
REQ-010 The block SHALL have port imem_addr, output, 32 bits: byte address to the combinational-read instruction memory.
REQ-011 The block SHALL have port imem_instr, input, 32 bits: instruction word returned for imem_addr in the same cycle.
REQ-012 The block SHALL have port fetch_valid, output, 1 bit: fetch_pc and fetch_instr hold a valid instruction.
REQ-013 The block SHALL have port fetch_pc, output, 32 bits: address of the fetched instruction.
REQ-014 The block SHALL have port fetch_instr, output, 32 bits: the fetched instruction word.
REQ-015 The block SHALL have port mepc, output, 32 bits: saved return address for the interrupt handler.
REQ-016 The block SHALL have port in_handler, output, 1 bit: an interrupt is being serviced.

Function
REQ-017 imem_addr SHALL equal the internal PC register combinationally; the low 2 bits SHALL be forced to 0.
REQ-018 The fetch output register SHALL capture {PC, imem_instr} with fetch_valid=1 on every non-stalled, non-flushed cycle: one-cycle latency from PC to fetch outputs.
REQ-019 Next-PC priority SHALL be, highest first: redirect_valid -> redirect_pc; mret -> mepc; accepted irq -> IRQ_VECTOR; stall -> hold PC; otherwise PC+4, wrapping modulo 2^32.
REQ-020 redirect_valid, mret or irq acceptance SHALL flush: fetch_valid=0 on the next edge, regardless of stall.
REQ-021 With stall=1 and no flush event, PC, fetch_valid, fetch_pc and fetch_instr SHALL hold their values.
REQ-022 The state machine SHALL have two states: RUN and HANDLER; reset state is RUN.
REQ-023 RUN->HANDLER SHALL occur when irq=1 and neither redirect_valid nor mret is asserted; on that edge mepc<=PC, which is the next unissued address, and PC<=IRQ_VECTOR.
REQ-024 An irq coinciding with redirect_valid SHALL be deferred; it is accepted on the first later cycle where it is still high and no higher-priority event is present; in that case mepc captures the redirect target.
REQ-025 In HANDLER, irq SHALL be ignored, with no nesting; mepc SHALL hold.
REQ-026 HANDLER->RUN SHALL occur on mret; PC<=mepc.
REQ-027 mret in RUN SHALL still load PC<=mepc and flush, with no state change.
REQ-028 in_handler SHALL be 1 exactly while the state is HANDLER.

Reset
REQ-029 When reset is asserted, asynchronously: PC=RESET_PC, state=RUN, fetch_valid=0, fetch_pc=0, fetch_instr=32'h0000_0013 (nop), mepc=0.
REQ-030 Reset mid-operation, including while in HANDLER, SHALL abandon all state; the first valid fetch after deassertion SHALL be at RESET_PC.

Verification
REQ-031 Reset, then release with stall=0 -> imem_addr sequence 0x0, 0x4, 0x8; fetch_valid rises one cycle after release with fetch_pc=0x0.
REQ-032 redirect_valid=1, redirect_pc=0x24 while PC=0x10 -> next imem_addr=0x24, fetch_valid=0 for one cycle, then fetch_pc=0x24.
REQ-033 irq=1 while PC=0x18 in RUN -> next imem_addr=0x500, mepc=0x18, in_handler=1; holding irq high over the following cycles causes no re-entry.
REQ-034 mret in HANDLER with mepc=0x18 -> imem_addr=0x18, in_handler=0; irq still high -> accepted one cycle later.
REQ-035 stall=1 for 3 cycles at PC=0x8 -> imem_addr stays 0x8 and fetch outputs are unchanged; redirect during stall still wins and flushes.
REQ-036 irq and redirect_valid (target 0x40) in the same cycle -> PC=0x40; the next cycle, irq is accepted with mepc=0x40.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing with redirect, single-level interrupt entry/return,
// stall hold and a one-cycle registered fetch output.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  input  logic        mret,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr,
  output logic [31:0] mepc,
  output logic        in_handler
);

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_mepc;
  logic        r_fetch_valid;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_fetch_instr;
  logic        r_in_handler;

  logic [31:0] w_pc_aligned;
  logic        w_irq_accept;
  logic        w_flush;
  logic [31:0] w_next_pc;

  assign w_pc_aligned = r_pc & ALIGN_MASK;
  // An irq only wins when no redirect or mret competes and no handler is active.
  assign w_irq_accept = irq && (r_state == RUN) && !redirect_valid && !mret;
  assign w_flush      = redirect_valid || mret || w_irq_accept;

  always_comb begin
    w_next_pc = w_pc_aligned + 32'd4;
    if (redirect_valid) begin
      w_next_pc = redirect_pc & ALIGN_MASK;
    end else if (mret) begin
      w_next_pc = r_mepc;
    end else if (w_irq_accept) begin
      w_next_pc = IRQ_VECTOR;
    end else if (stall) begin
      w_next_pc = r_pc;
    end else begin
      w_next_pc = w_pc_aligned + 32'd4;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= RUN;
      r_pc          <= RESET_PC;
      r_mepc        <= 32'h0000_0000;
      r_fetch_valid <= 1'b0;
      r_fetch_pc    <= 32'h0000_0000;
      r_fetch_instr <= NOP_INSTR;
      r_in_handler  <= 1'b0;
    end else begin
      r_pc <= w_next_pc;

      if (w_flush) begin
        r_fetch_valid <= 1'b0;
      end else if (!stall) begin
        r_fetch_valid <= 1'b1;
        r_fetch_pc    <= w_pc_aligned;
        r_fetch_instr <= imem_instr;
      end else begin
        r_fetch_valid <= r_fetch_valid;
      end

      case (r_state)
        RUN: begin
          // mepc takes the next unissued address, which after a deferred irq is the redirect target.
          if (w_irq_accept) begin
            r_state      <= HANDLER;
            r_mepc       <= w_pc_aligned;
            r_in_handler <= 1'b1;
          end else begin
            r_state      <= RUN;
            r_in_handler <= 1'b0;
          end
        end
        HANDLER: begin
          if (mret) begin
            r_state      <= RUN;
            r_in_handler <= 1'b0;
          end else begin
            r_state      <= HANDLER;
            r_in_handler <= 1'b1;
          end
        end
        default: begin
          r_state      <= RUN;
          r_in_handler <= 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = w_pc_aligned;
  assign fetch_valid = r_fetch_valid;
  assign fetch_pc    = r_fetch_pc;
  assign fetch_instr = r_fetch_instr;
  assign mepc        = r_mepc;
  assign in_handler  = r_in_handler;

endmodule

// File: tb/tb_instr_fetch.sv
// Table-driven bench for instr_fetch: a cycle-by-cycle vector table plus hand-written
// reset sequences; a combinational memory model supplies instruction words.
module tb_instr_fetch;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        irq;
  logic        mret;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic [31:0] mepc;
  logic        in_handler;

  int n_vec;
  int n_err;

  typedef struct {
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        irq;
    logic        mret;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_fpc;
    logic [31:0] e_mepc;
    logic        e_ih;
  } vec_t;

  vec_t vecs[$];

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .IRQ_VECTOR(32'h0000_0500)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .irq           (irq),
    .mret          (mret),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .fetch_valid   (fetch_valid),
    .fetch_pc      (fetch_pc),
    .fetch_instr   (fetch_instr),
    .mepc          (mepc),
    .in_handler    (in_handler)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic rv, input logic [31:0] rpc, input logic i,
                     input logic m, input logic [31:0] ea, input logic efv,
                     input logic [31:0] efpc, input logic [31:0] emepc, input logic eih);
    vec_t v;
    v.stall = s; v.rv = rv; v.rpc = rpc; v.irq = i; v.mret = m;
    v.e_addr = ea; v.e_fv = efv; v.e_fpc = efpc; v.e_mepc = emepc; v.e_ih = eih;
    vecs.push_back(v);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0000_0000;
    irq = 1'b0;
    mret = 1'b0;

    //   stl rv   rpc           irq mret  addr          fv   fpc           mepc          ih
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0004,1'b1,32'h0000_0000,32'h0000_0000,1'b0);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0008,1'b1,32'h0000_0004,32'h0000_0000,1'b0);
    add(1'b1,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0008,1'b1,32'h0000_0004,32'h0000_0000,1'b0);
    add(1'b1,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0008,1'b1,32'h0000_0004,32'h0000_0000,1'b0);
    add(1'b1,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0008,1'b1,32'h0000_0004,32'h0000_0000,1'b0);
    add(1'b1,1'b1,32'h0000_0010,1'b0,1'b0, 32'h0000_0010,1'b0,32'h0000_0000,32'h0000_0000,1'b0);
    add(1'b0,1'b1,32'h0000_0024,1'b0,1'b0, 32'h0000_0024,1'b0,32'h0000_0000,32'h0000_0000,1'b0);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0028,1'b1,32'h0000_0024,32'h0000_0000,1'b0);
    add(1'b0,1'b1,32'h0000_0018,1'b0,1'b0, 32'h0000_0018,1'b0,32'h0000_0000,32'h0000_0000,1'b0);
    add(1'b0,1'b0,32'h0000_0000,1'b1,1'b0, 32'h0000_0500,1'b0,32'h0000_0000,32'h0000_0018,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b1,1'b0, 32'h0000_0504,1'b1,32'h0000_0500,32'h0000_0018,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b1,1'b0, 32'h0000_0508,1'b1,32'h0000_0504,32'h0000_0018,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b1,1'b1, 32'h0000_0018,1'b0,32'h0000_0000,32'h0000_0018,1'b0);
    add(1'b0,1'b0,32'h0000_0000,1'b1,1'b0, 32'h0000_0500,1'b0,32'h0000_0000,32'h0000_0018,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b1, 32'h0000_0018,1'b0,32'h0000_0000,32'h0000_0018,1'b0);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_001C,1'b1,32'h0000_0018,32'h0000_0018,1'b0);
    add(1'b0,1'b1,32'h0000_0040,1'b1,1'b0, 32'h0000_0040,1'b0,32'h0000_0000,32'h0000_0018,1'b0);
    add(1'b0,1'b0,32'h0000_0000,1'b1,1'b0, 32'h0000_0500,1'b0,32'h0000_0000,32'h0000_0040,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0504,1'b1,32'h0000_0500,32'h0000_0040,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b1, 32'h0000_0040,1'b0,32'h0000_0000,32'h0000_0040,1'b0);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b1, 32'h0000_0040,1'b0,32'h0000_0000,32'h0000_0040,1'b0);
    add(1'b1,1'b0,32'h0000_0000,1'b1,1'b0, 32'h0000_0500,1'b0,32'h0000_0000,32'h0000_0040,1'b1);
    add(1'b0,1'b1,32'h0000_0100,1'b1,1'b0, 32'h0000_0100,1'b0,32'h0000_0000,32'h0000_0040,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b1,1'b0, 32'h0000_0104,1'b1,32'h0000_0100,32'h0000_0040,1'b1);
    add(1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0, 32'hFFFF_FFFC,1'b0,32'h0000_0000,32'h0000_0040,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0000,1'b1,32'hFFFF_FFFC,32'h0000_0040,1'b1);
    add(1'b0,1'b1,32'h0000_0023,1'b0,1'b0, 32'h0000_0020,1'b0,32'h0000_0000,32'h0000_0040,1'b1);
    add(1'b0,1'b0,32'h0000_0000,1'b0,1'b0, 32'h0000_0024,1'b1,32'h0000_0020,32'h0000_0040,1'b1);

    repeat (2) @(posedge clock);
    #1;
    check("rst_addr",  imem_addr,   32'h0000_0000);
    check("rst_fv",    {31'd0, fetch_valid}, 32'd0);
    check("rst_fpc",   fetch_pc,    32'h0000_0000);
    check("rst_instr", fetch_instr, 32'h0000_0013);
    check("rst_mepc",  mepc,        32'h0000_0000);
    check("rst_ih",    {31'd0, in_handler}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall          = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      irq            = vecs[i].irq;
      mret           = vecs[i].mret;
      @(posedge clock);
      #1;
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_fv", i), {31'd0, fetch_valid}, {31'd0, vecs[i].e_fv});
      check($sformatf("v%0d_mepc", i), mepc, vecs[i].e_mepc);
      check($sformatf("v%0d_ih", i), {31'd0, in_handler}, {31'd0, vecs[i].e_ih});
      if (vecs[i].e_fv) begin
        check($sformatf("v%0d_fpc", i), fetch_pc, vecs[i].e_fpc);
        check($sformatf("v%0d_instr", i), fetch_instr, mem_word(vecs[i].e_fpc));
      end
    end

    // Asynchronous reset while in the handler, applied between clock edges.
    stall = 1'b0; redirect_valid = 1'b0; irq = 1'b0; mret = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_addr",  imem_addr,   32'h0000_0000);
    check("arst_fv",    {31'd0, fetch_valid}, 32'd0);
    check("arst_fpc",   fetch_pc,    32'h0000_0000);
    check("arst_instr", fetch_instr, 32'h0000_0013);
    check("arst_mepc",  mepc,        32'h0000_0000);
    check("arst_ih",    {31'd0, in_handler}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_fv",    {31'd0, fetch_valid}, 32'd1);
    check("post_fpc",   fetch_pc,    32'h0000_0000);
    check("post_instr", fetch_instr, mem_word(32'h0000_0000));
    check("post_addr",  imem_addr,   32'h0000_0004);
    check("post_ih",    {31'd0, in_handler}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
